// File: rtl/instruction_fetch.sv
// Instruction fetch stage: walks an 8-bit PC through a combinational instruction
// memory and presents one registered instruction byte per cycle to decode.
// Handshake: fetch_valid/fetch_instruction/fetch_pc are held stable while
// fetch_valid=1 and fetch_ready=0; a transfer completes on any rising edge where
// fetch_valid=1 and fetch_ready=1 and no redirect is requested in that cycle.
// A redirect discards the presented instruction, even if fetch_ready=1.
module instruction_fetch #(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [7:0]  instruction_address,
  input  logic [7:0]  instruction_data,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_address,
  input  logic        fetch_ready,
  output logic        fetch_valid,
  output logic [7:0]  fetch_instruction,
  output logic [7:0]  fetch_pc,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic [7:0]  fetch_instruction_q, fetch_instruction_d;
  logic [7:0]  fetch_pc_q, fetch_pc_d;
  logic [15:0] fetch_count_q, fetch_count_d;

  logic load;
  logic handshake;

  // A new byte may be captured when running, not redirected, and the output slot is free or draining.
  assign load      = (state_q == ST_RUN) && !redirect_valid && (!fetch_valid_q || fetch_ready);
  assign handshake = fetch_valid_q && fetch_ready && !redirect_valid;

  // State register plus datapath registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q             <= ST_RUN;
      pc_q                <= RESET_PC;
      fetch_valid_q       <= 1'b0;
      fetch_instruction_q <= 8'h00;
      fetch_pc_q          <= 8'h00;
      fetch_count_q       <= 16'h0000;
    end else begin
      state_q             <= state_d;
      pc_q                <= pc_d;
      fetch_valid_q       <= fetch_valid_d;
      fetch_instruction_q <= fetch_instruction_d;
      fetch_pc_q          <= fetch_pc_d;
      fetch_count_q       <= fetch_count_d;
    end
  end

  // Next-state logic: redirect wins, otherwise a loaded halt opcode parks the FSM.
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = ST_RUN;
    end else if (load && (instruction_data == HALT_OPCODE)) begin
      state_d = ST_HALT;
    end
  end

  // Datapath next values: redirect, load, drain-in-halt, or hold (stall).
  always_comb begin
    pc_d                = pc_q;
    fetch_valid_d       = fetch_valid_q;
    fetch_instruction_d = fetch_instruction_q;
    fetch_pc_d          = fetch_pc_q;
    if (redirect_valid) begin
      pc_d          = redirect_address;
      fetch_valid_d = 1'b0;
    end else if (load) begin
      fetch_instruction_d = instruction_data;
      fetch_pc_d          = pc_q;
      fetch_valid_d       = 1'b1;
      pc_d                = pc_q + 8'd1;
    end else if (fetch_valid_q && fetch_ready) begin
      // Only reachable in HALT: last instruction accepted, nothing follows.
      fetch_valid_d = 1'b0;
    end
  end

  // Handshake counter saturates at all-ones and survives redirects.
  always_comb begin
    fetch_count_d = fetch_count_q;
    if (handshake && (fetch_count_q != 16'hFFFF)) begin
      fetch_count_d = fetch_count_q + 16'd1;
    end
  end

  // Output decode: halted reflects the registered state directly.
  always_comb begin
    halted              = (state_q == ST_HALT);
    instruction_address = pc_q;
    fetch_valid         = fetch_valid_q;
    fetch_instruction   = fetch_instruction_q;
    fetch_pc            = fetch_pc_q;
    fetch_count         = fetch_count_q;
  end

endmodule
